// File: rtl/conv1_layer1_dense_accum_pkg.sv
// Shared constants, FSM state type and lane helper for the conv1 layer1 dense accumulator.
// Optional build macro: CONV1_DENSE_ACC_SATURATE_EN (saturating accumulator).
package conv1_layer1_dense_accum_pkg;

    localparam int LANES = 25;
    localparam int DW    = 16;
    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } acc_state_e;

    // Lane i of the product bus occupies bits [DW*i+DW-1 : DW*i].
    function automatic logic [DW-1:0] lane_slice(input logic [LANES*DW-1:0] bus,
                                                 input int unsigned idx);
        return bus[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/conv1_layer1_dense_accum_add5_reg.sv
// Registered 5-input signed adder with hold enable; inputs are sign-extended to OW.
module conv1_dense_add5_reg #(
    parameter int IW = 16,
    parameter int OW = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [4:0][IW-1:0] din,
    output logic [OW-1:0]      sum
);

    logic [OW-1:0] sum_reg;
    logic [OW-1:0] sum_next;

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < 5; i++) begin
            sum_next = sum_next + OW'($signed(din[i]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= sum_next;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/conv1_layer1_dense_accum.sv
// Reduces 25-lane Q8.8 product vectors through a 2-stage adder tree and accumulates vec_num of them.
// Build macro CONV1_DENSE_ACC_SATURATE_EN makes the accumulator add saturate (sticky per result).
module conv1_layer1_dense_accum
    import conv1_layer1_dense_accum_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      vec_num,
    input  logic [LANES*DW-1:0]   mult_res_w,
    input  logic                  mult_res_v_w,
    output logic                  halt_out,
    output logic [ACC_W-1:0]      acc_out,
    output logic                  acc_out_v,
    input  logic                  acc_out_rdy,
    output logic                  busy,
    output logic                  drop_err
);

    acc_state_e                  state_reg;
    logic [CNT_W-1:0]            vec_num_reg;
    logic [CNT_W-1:0]            count_reg;
    logic                        flush_cnt_reg;
    logic                        v1_reg, v2_reg;
    logic [ACC_W-1:0]            acc_reg, acc_next;
    logic [ACC_W-1:0]            acc_out_reg;
    logic                        acc_out_v_reg;
    logic                        drop_err_reg;
    logic                        accept;
    logic                        tree_en;
    logic [4:0][4:0][DW-1:0]     s1_din;
    logic [4:0][ACC_W-1:0]       s1_sum;
    logic [ACC_W-1:0]            s2_sum;

    assign halt_out  = acc_out_v_reg && !acc_out_rdy;
    assign tree_en   = !halt_out;
    assign accept    = mult_res_v_w && !halt_out && (state_reg == RUN);
    assign busy      = (state_reg != IDLE);
    assign acc_out   = acc_out_reg;
    assign acc_out_v = acc_out_v_reg;
    assign drop_err  = drop_err_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_s1
            for (gj = 0; gj < 5; gj++) begin : g_lane
                assign s1_din[gi][gj] = lane_slice(mult_res_w, gi*5 + gj);
            end
            conv1_dense_add5_reg #(.IW(DW), .OW(ACC_W)) u_s1 (
                .clk (clk),
                .rst (rst),
                .en  (tree_en),
                .din (s1_din[gi]),
                .sum (s1_sum[gi])
            );
        end
    endgenerate

    conv1_dense_add5_reg #(.IW(ACC_W), .OW(ACC_W)) u_s2 (
        .clk (clk),
        .rst (rst),
        .en  (tree_en),
        .din (s1_sum),
        .sum (s2_sum)
    );

`ifdef CONV1_DENSE_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic             sat_reg, sat_next;
    logic [ACC_W:0]   sum_ext;

    // Once clamped, the result stays at the bound until the next start.
    always_comb begin
        acc_next = acc_reg;
        sat_next = sat_reg;
        sum_ext  = {acc_reg[ACC_W-1], acc_reg} + {s2_sum[ACC_W-1], s2_sum};
        if (v2_reg && !sat_reg) begin
            if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                sat_next = 1'b1;
                acc_next = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
            end else begin
                acc_next = sum_ext[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_reg <= 1'b0;
        end else if (state_reg == IDLE && start && vec_num != '0) begin
            sat_reg <= 1'b0;
        end else if (tree_en) begin
            sat_reg <= sat_next;
        end
    end
`else
    always_comb begin
        acc_next = acc_reg;
        if (v2_reg) begin
            acc_next = acc_reg + s2_sum;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            vec_num_reg   <= '0;
            count_reg     <= '0;
            flush_cnt_reg <= 1'b0;
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            acc_reg       <= '0;
            acc_out_reg   <= '0;
            acc_out_v_reg <= 1'b0;
            drop_err_reg  <= 1'b0;
        end else begin
            drop_err_reg <= mult_res_v_w && (state_reg != RUN);
            if (tree_en) begin
                v1_reg  <= accept;
                v2_reg  <= v1_reg;
                acc_reg <= acc_next;
            end
            case (state_reg)
                IDLE: begin
                    if (start && vec_num != '0) begin
                        vec_num_reg <= vec_num;
                        count_reg   <= '0;
                        acc_reg     <= '0;
                        state_reg   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        count_reg <= count_reg + CNT_W'(1);
                        if (count_reg + CNT_W'(1) == vec_num_reg) begin
                            flush_cnt_reg <= 1'b0;
                            state_reg     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Last vector leaves S2 on this edge, so publish the post-add value.
                    flush_cnt_reg <= 1'b1;
                    if (flush_cnt_reg) begin
                        acc_out_reg   <= acc_next;
                        acc_out_v_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (acc_out_rdy) begin
                        acc_out_v_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_layer1_dense_accum.sv
// Scoreboard bench for conv1_layer1_dense_accum: expected sums queued at stimulus, popped on handshake.
module tb_conv1_layer1_dense_accum;
    import conv1_layer1_dense_accum_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [CNT_W-1:0]      vec_num;
    logic [LANES*DW-1:0]   mult_res_w;
    logic                  mult_res_v_w;
    logic                  halt_out;
    logic [ACC_W-1:0]      acc_out;
    logic                  acc_out_v;
    logic                  acc_out_rdy;
    logic                  busy;
    logic                  drop_err;

    logic [ACC_W-1:0]      exp_q[$];
    int                    n_checks = 0;
    int                    n_errors = 0;

    always #5 clk = ~clk;

    conv1_layer1_dense_accum dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .vec_num      (vec_num),
        .mult_res_w   (mult_res_w),
        .mult_res_v_w (mult_res_v_w),
        .halt_out     (halt_out),
        .acc_out      (acc_out),
        .acc_out_v    (acc_out_v),
        .acc_out_rdy  (acc_out_rdy),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Reference: n identical vectors of 25 equal lanes, summed in 64-bit and reduced to ACC_W.
    function automatic logic [ACC_W-1:0] model(input logic [DW-1:0] lane, input int n);
        longint acc;
        longint vsum;
        longint hi;
        longint lo;
`ifdef CONV1_DENSE_ACC_SATURATE_EN
        bit sat;
        sat = 1'b0;
`endif
        acc  = 0;
        hi   = (longint'(1) << (ACC_W-1)) - 1;
        lo   = -(longint'(1) << (ACC_W-1));
        vsum = longint'($signed(lane)) * LANES;
        for (int i = 0; i < n; i++) begin
`ifdef CONV1_DENSE_ACC_SATURATE_EN
            if (!sat) begin
                acc += vsum;
                if (acc > hi) begin
                    acc = hi;
                    sat = 1'b1;
                end else if (acc < lo) begin
                    acc = lo;
                    sat = 1'b1;
                end
            end
`else
            acc += vsum;
`endif
        end
        if (acc > hi + (longint'(1) << ACC_W)) acc = acc;
        return acc[ACC_W-1:0];
    endfunction

    // Handshake monitor: every delivered result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && acc_out_v && acc_out_rdy) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
                check("sb_result", acc_out, exp_q.pop_front());
            end
        end
    end

    task automatic run_vec(input logic [DW-1:0] lane, input int n);
        int k;
        bit busy_ok;
        exp_q.push_back(model(lane, n));
        @(posedge clk); #1;
        start   = 1'b1;
        vec_num = CNT_W'(n);
        @(posedge clk); #1;
        start        = 1'b0;
        mult_res_w   = {LANES{lane}};
        mult_res_v_w = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        mult_res_v_w = 1'b0;
        k       = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            k++;
            busy_ok &= busy;
        end while (!acc_out_v && k < 40);
        check("result_latency", 64'(k), 64'd3);
        check("busy_during_run", 64'(busy_ok), 64'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 20);
        check("return_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [ACC_W-1:0] hold_exp;
        rst          = 1'b0;
        start        = 1'b0;
        vec_num      = '0;
        mult_res_w   = '0;
        mult_res_v_w = 1'b0;
        acc_out_rdy  = 1'b1;

        repeat (3) @(negedge clk);
        check("reset_acc_out", acc_out, 64'd0);
        check("reset_flags", {acc_out_v, busy, halt_out, drop_err}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_vec(16'h0100, 1);
        wait_idle();
        run_vec(16'h0100, 4);
        wait_idle();
        run_vec(16'hFF00, 2);
        wait_idle();

        // Backpressure: result held while the consumer stalls.
        acc_out_rdy = 1'b0;
        hold_exp    = model(16'h0100, 2);
        run_vec(16'h0100, 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            mult_res_v_w = (i == 1);
            start        = (i == 2);
            vec_num      = 8'd3;
            @(negedge clk);
            check("hold_halt", 64'(halt_out), 64'd1);
            check("hold_acc_stable", acc_out, hold_exp);
            check("hold_drop_err", 64'(drop_err), 64'(i == 2));
        end
        @(posedge clk); #1;
        mult_res_v_w = 1'b0;
        start        = 1'b0;
        acc_out_rdy  = 1'b1;
        wait_idle();
        @(negedge clk);
        check("no_restart_after_hold", {acc_out_v, busy}, 64'd0);

        // Valid while idle is discarded with a one-cycle error pulse.
        @(posedge clk); #1;
        mult_res_w   = {LANES{16'h0100}};
        mult_res_v_w = 1'b1;
        @(posedge clk); #1;
        mult_res_v_w = 1'b0;
        @(negedge clk);
        check("idle_drop_pulse", {drop_err, busy}, 64'd2);
        @(negedge clk);
        check("idle_drop_clear", 64'(drop_err), 64'd0);

        // Zero-length request is ignored.
        @(posedge clk); #1;
        start   = 1'b1;
        vec_num = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_zero_ignored", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        start   = 1'b1;
        vec_num = 8'd4;
        @(posedge clk); #1;
        start        = 1'b0;
        mult_res_v_w = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mult_res_v_w = 1'b0;
        rst          = 1'b0;
        #1;
        check("midrun_reset_acc", acc_out, 64'd0);
        check("midrun_reset_flags", {acc_out_v, busy, halt_out}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_vec(16'h0100, 2);
        wait_idle();

        run_vec(16'h7FFF, 255);
        wait_idle();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
